// File: rtl/perf_trigger_master.sv
// Turns hardware start/stop/global-reset pulses into Avalon-MM writes to the perf counter slave.
// Latency: pulse in cycle c reaches the bus in cycle c+2; at most one write per two cycles.
// Backpressure: waitrequest holds address/writedata/write; pulses arriving while busy queue as pending flags.
// PERF_TRIG_DROP_CNT_EN enables the saturating drop_count; otherwise drop_count reads 0.
module perf_trigger_master #(
    parameter int NUM_SECTIONS = 4,
    parameter int ADDR_W       = 4,
    parameter int DATA_W       = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_SECTIONS-1:0] sec_start,
    input  logic [NUM_SECTIONS-1:0] sec_stop,
    input  logic                    greset_req,
    input  logic                    drop_clr,
    input  logic                    waitrequest,
    output logic [ADDR_W-1:0]       address,
    output logic                    write,
    output logic                    begintransfer,
    output logic [DATA_W-1:0]       writedata,
    output logic                    busy,
    output logic                    drop_flag,
    output logic [7:0]              drop_count
);
    localparam int NREQ = 2 * NUM_SECTIONS + 1;

    typedef enum logic [1:0] {IDLE, XFER, HOLD} state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   pend_q, pend_d;
    logic [NREQ-1:0]   pulse, grant, drop_vec;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [DATA_W-1:0] writedata_q, writedata_d;
    logic              write_q, write_d;
    logic              bt_q, bt_d;
    logic              drop_flag_q, drop_flag_d;
    logic              found;
    int                gnt_idx;
    int                sel_addr;

    always_comb begin
        // Bit 0 is greset, then stops, then starts: lowest index wins.
        pulse   = {sec_start, sec_stop, greset_req};
        found   = 1'b0;
        gnt_idx = 0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && pend_q[i] && state_q == IDLE) begin
                found   = 1'b1;
                gnt_idx = i;
            end
        end
        grant = found ? (NREQ'(1) << gnt_idx) : '0;

        if (gnt_idx == 0)
            sel_addr = 0;
        else if (gnt_idx <= NUM_SECTIONS)
            sel_addr = 4 * (gnt_idx - 1);
        else
            sel_addr = 4 * (gnt_idx - 1 - NUM_SECTIONS) + 1;

        // A pulse landing on its own grant cycle re-arms the flag instead of dropping.
        pend_d      = (pend_q & ~grant) | pulse;
        drop_vec    = pulse & pend_q & ~grant;
        drop_flag_d = drop_clr ? 1'b0 : (drop_flag_q | (|drop_vec));

        state_d     = state_q;
        address_d   = address_q;
        writedata_d = writedata_q;
        write_d     = write_q;
        bt_d        = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d     = XFER;
                    address_d   = ADDR_W'(sel_addr);
                    writedata_d = (gnt_idx == 0) ? DATA_W'(1) : '0;
                    write_d     = 1'b1;
                    bt_d        = 1'b1;
                end
            end
            XFER: begin
                if (waitrequest) begin
                    state_d = HOLD;
                end else begin
                    state_d = IDLE;
                    write_d = 1'b0;
                end
            end
            HOLD: begin
                if (!waitrequest) begin
                    state_d = IDLE;
                    write_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            pend_q      <= '0;
            address_q   <= '0;
            writedata_q <= '0;
            write_q     <= 1'b0;
            bt_q        <= 1'b0;
            drop_flag_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            address_q   <= address_d;
            writedata_q <= writedata_d;
            write_q     <= write_d;
            bt_q        <= bt_d;
            drop_flag_q <= drop_flag_d;
        end
    end

`ifdef PERF_TRIG_DROP_CNT_EN
    logic [7:0] drop_count_q, drop_count_d;
    int         drop_sum;

    always_comb begin
        drop_sum = int'(drop_count_q) + $countones(drop_vec);
        if (drop_clr)
            drop_count_d = '0;
        else if (drop_sum > 255)
            drop_count_d = 8'hFF;
        else
            drop_count_d = 8'(drop_sum);
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            drop_count_q <= '0;
        else
            drop_count_q <= drop_count_d;
    end

    assign drop_count = drop_count_q;
`else
    assign drop_count = 8'd0;
`endif

    assign address       = address_q;
    assign writedata     = writedata_q;
    assign write         = write_q;
    assign begintransfer = bt_q;
    assign drop_flag     = drop_flag_q;
    assign busy          = (state_q != IDLE) || (|pend_q);
endmodule

// File: tb/tb_perf_trigger_master.sv
// Bench for perf_trigger_master: directed scenarios plus a randomized run against a transaction-level model.
// Bus timing is modelled as "bus occupied until a write sees waitrequest low".
module tb_perf_trigger_master;
    localparam int N = 4;

`ifdef PERF_TRIG_DROP_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [N-1:0]  sec_start = '0;
    logic [N-1:0]  sec_stop = '0;
    logic          greset_req = 1'b0;
    logic          drop_clr = 1'b0;
    logic          waitrequest = 1'b0;
    logic [3:0]    address;
    logic          write;
    logic          begintransfer;
    logic [31:0]   writedata;
    logic          busy;
    logic          drop_flag;
    logic [7:0]    drop_count;

    int n_checks = 0;
    int n_fail   = 0;

    perf_trigger_master #(.NUM_SECTIONS(N), .ADDR_W(4), .DATA_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .sec_start(sec_start), .sec_stop(sec_stop),
        .greset_req(greset_req), .drop_clr(drop_clr), .waitrequest(waitrequest),
        .address(address), .write(write), .begintransfer(begintransfer),
        .writedata(writedata), .busy(busy), .drop_flag(drop_flag), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "timeout");
    end

    function automatic logic [7:0] exp_cnt(input int c);
        if (!CNT_EN) return 8'd0;
        return (c > 255) ? 8'd255 : 8'(c);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; sec_start = '1; sec_stop = '1; greset_req = 1'b1; drop_clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({address, write, begintransfer, writedata, busy, drop_flag, drop_count} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs: got addr=%0h wr=%b bt=%b wd=%0h busy=%b df=%b dc=%0d required all 0",
                         address, write, begintransfer, writedata, busy, drop_flag, drop_count);
            end
        end
        step();
        reset_n = 1'b1; sec_start = '0; sec_stop = '0; greset_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if (write !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_release: got wr=%b busy=%b required 0 0", write, busy);
            end
        end
    endtask

    task automatic test_single_start();
        int bt_cnt = 0;
        step();
        sec_start = 4'b0100;
        step();
        sec_start = '0;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            bt_cnt += int'(begintransfer);
            if (i == 1) begin
                n_checks++;
                if (write !== 1'b0) begin
                    n_fail++; $display("FAIL start_c1: got wr=%b required 0", write);
                end
            end
            if (i == 2) begin
                n_checks++;
                if (write !== 1'b1 || begintransfer !== 1'b1 || address !== 4'd9 || writedata !== 32'd0) begin
                    n_fail++;
                    $display("FAIL start_c2: got wr=%b bt=%b addr=%0d wd=%0h required 1 1 9 0",
                             write, begintransfer, address, writedata);
                end
            end
            if (i == 3) begin
                n_checks++;
                if (write !== 1'b0) begin
                    n_fail++; $display("FAIL start_c3: got wr=%b required 0", write);
                end
            end
        end
        n_checks++;
        if (bt_cnt !== 1) begin
            n_fail++; $display("FAIL start_bt_count: got %0d required 1", bt_cnt);
        end
    endtask

    task automatic test_priority();
        int    got_a[$];
        int    got_d[$];
        int    exp_a[3] = '{0, 4, 13};
        int    exp_d[3] = '{1, 0, 0};
        logic  prev_wr = 1'b0;
        int    gap_bad = 0;
        step();
        greset_req = 1'b1; sec_stop = 4'b0010; sec_start = 4'b1000;
        step();
        greset_req = 1'b0; sec_stop = '0; sec_start = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (begintransfer) begin
                got_a.push_back(int'(address));
                got_d.push_back(int'(writedata));
                if (prev_wr) gap_bad++;
            end
            prev_wr = write;
        end
        n_checks++;
        if (got_a.size() != 3) begin
            n_fail++; $display("FAIL prio_count: got %0d writes required 3", got_a.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (got_a[k] != exp_a[k] || got_d[k] != exp_d[k]) begin
                    n_fail++;
                    $display("FAIL prio_order[%0d]: got addr=%0d wd=%0d required addr=%0d wd=%0d",
                             k, got_a[k], got_d[k], exp_a[k], exp_d[k]);
                end
            end
        end
        n_checks++;
        if (gap_bad != 0) begin
            n_fail++; $display("FAIL prio_gap: got %0d back-to-back writes required 0", gap_bad);
        end
    endtask

    task automatic test_hold();
        int wcnt = 0, btcnt = 0, bad = 0;
        step();
        sec_stop = 4'b1000; waitrequest = 1'b1;
        step();
        sec_stop = '0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (write) begin
                wcnt++;
                if (address !== 4'd12 || writedata !== 32'd0) bad++;
            end
            if (begintransfer) begin
                btcnt++;
                if (i != 2) bad++;
            end
            step();
            if (i == 6) waitrequest = 1'b0;
        end
        n_checks++;
        if (wcnt != 6) begin
            n_fail++; $display("FAIL hold_write_cycles: got %0d required 6", wcnt);
        end
        n_checks++;
        if (btcnt != 1) begin
            n_fail++; $display("FAIL hold_bt_count: got %0d required 1", btcnt);
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL hold_stable: got %0d bad cycles required 0", bad);
        end
    endtask

    task automatic test_drop();
        int bt_all = 0, bt_one = 0;
        step();
        sec_stop = 4'b0100; waitrequest = 1'b1;
        step();
        sec_stop = '0;
        step(); sec_start = 4'b0001;
        step(); sec_start = '0;
        step(); sec_start = 4'b0001;
        step(); sec_start = '0;
        @(negedge clk);
        n_checks++;
        if (drop_flag !== 1'b1 || drop_count !== exp_cnt(1)) begin
            n_fail++; $display("FAIL drop_one: got df=%b dc=%0d required 1 %0d", drop_flag, drop_count, exp_cnt(1));
        end
        waitrequest = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (begintransfer) begin
                bt_all++;
                if (address === 4'd1 && writedata === 32'd0) bt_one++;
            end
        end
        n_checks++;
        if (bt_all != 1 || bt_one != 1) begin
            n_fail++; $display("FAIL drop_single_write: got %0d writes (%0d to addr 1) required 1 1", bt_all, bt_one);
        end
        step(); drop_clr = 1'b1;
        step(); drop_clr = 1'b0;
        @(negedge clk);
        n_checks++;
        if (drop_flag !== 1'b0 || drop_count !== 8'd0) begin
            n_fail++; $display("FAIL drop_clear: got df=%b dc=%0d required 0 0", drop_flag, drop_count);
        end
        step();
        sec_stop = 4'b0100; waitrequest = 1'b1;
        step();
        sec_stop = '0; sec_start = 4'b0001;
        repeat (301) step();
        sec_start = '0;
        @(negedge clk);
        n_checks++;
        if (drop_flag !== 1'b1 || drop_count !== exp_cnt(300)) begin
            n_fail++; $display("FAIL drop_saturate: got df=%b dc=%0d required 1 %0d", drop_flag, drop_count, exp_cnt(300));
        end
        drop_clr = 1'b1; sec_start = 4'b0001;
        step();
        drop_clr = 1'b0; sec_start = '0;
        @(negedge clk);
        n_checks++;
        if (drop_flag !== 1'b0 || drop_count !== 8'd0) begin
            n_fail++; $display("FAIL drop_clr_wins: got df=%b dc=%0d required 0 0", drop_flag, drop_count);
        end
        sec_start = 4'b0011;
        step(); step();
        sec_start = '0;
        @(negedge clk);
        n_checks++;
        if (drop_flag !== 1'b1 || drop_count !== exp_cnt(3)) begin
            n_fail++; $display("FAIL drop_multi: got df=%b dc=%0d required 1 %0d", drop_flag, drop_count, exp_cnt(3));
        end
        waitrequest = 1'b0;
        repeat (30) step();
        drop_clr = 1'b1;
        step();
        drop_clr = 1'b0;
        repeat (2) step();
    endtask

    task automatic test_random();
        bit m_g;
        bit m_stop[N];
        bit m_start[N];
        bit m_act, m_first, m_flag, m_busy;
        int m_addr, m_wd, m_cnt, gk, nd;
        m_g = 0; m_act = 0; m_first = 0; m_flag = 0; m_addr = 0; m_wd = 0; m_cnt = 0;
        for (int s = 0; s < N; s++) begin m_stop[s] = 0; m_start[s] = 0; end
        @(negedge clk);
        for (int cyc = 0; cyc < 2000; cyc++) begin
            greset_req  = ($urandom_range(0, 15) == 0);
            for (int s = 0; s < N; s++) begin
                sec_stop[s]  = ($urandom_range(0, 9) == 0);
                sec_start[s] = ($urandom_range(0, 9) == 0);
            end
            waitrequest = ($urandom_range(0, 2) == 0);
            drop_clr    = ($urandom_range(0, 49) == 0);
            @(posedge clk);
            gk = -1;
            if (!m_act) begin
                if (m_g) gk = 0;
                for (int s = 0; s < N; s++) if (gk < 0 && m_stop[s]) gk = 1 + s;
                for (int s = 0; s < N; s++) if (gk < 0 && m_start[s]) gk = 1 + N + s;
            end
            nd = 0;
            if (greset_req && m_g && gk != 0) nd++;
            for (int s = 0; s < N; s++) begin
                if (sec_stop[s] && m_stop[s] && gk != 1 + s) nd++;
                if (sec_start[s] && m_start[s] && gk != 1 + N + s) nd++;
            end
            if (gk == 0) m_g = 0;
            for (int s = 0; s < N; s++) begin
                if (gk == 1 + s) m_stop[s] = 0;
                if (gk == 1 + N + s) m_start[s] = 0;
            end
            if (greset_req) m_g = 1;
            for (int s = 0; s < N; s++) begin
                if (sec_stop[s]) m_stop[s] = 1;
                if (sec_start[s]) m_start[s] = 1;
            end
            if (gk >= 0) begin
                m_act = 1; m_first = 1;
                if (gk == 0) begin m_addr = 0; m_wd = 1; end
                else if (gk <= N) begin m_addr = 4 * (gk - 1); m_wd = 0; end
                else begin m_addr = 4 * (gk - 1 - N) + 1; m_wd = 0; end
            end else if (m_act) begin
                m_first = 0;
                if (!waitrequest) m_act = 0;
            end
            if (drop_clr) begin m_flag = 0; m_cnt = 0; end
            else begin
                if (nd > 0) m_flag = 1;
                m_cnt = (m_cnt + nd > 255) ? 255 : m_cnt + nd;
            end
            m_busy = m_act | m_g;
            for (int s = 0; s < N; s++) m_busy = m_busy | m_stop[s] | m_start[s];
            @(negedge clk);
            n_checks++;
            if (write !== m_act || begintransfer !== m_first) begin
                n_fail++; $display("FAIL rnd_ctrl @%0d: got wr=%b bt=%b required %b %b", cyc, write, begintransfer, m_act, m_first);
            end
            if (m_act) begin
                n_checks++;
                if (address !== 4'(m_addr) || writedata !== 32'(m_wd)) begin
                    n_fail++; $display("FAIL rnd_data @%0d: got addr=%0d wd=%0d required %0d %0d", cyc, address, writedata, m_addr, m_wd);
                end
            end
            n_checks++;
            if (busy !== m_busy) begin
                n_fail++; $display("FAIL rnd_busy @%0d: got %b required %b", cyc, busy, m_busy);
            end
            n_checks++;
            if (drop_flag !== m_flag || drop_count !== exp_cnt(m_cnt)) begin
                n_fail++; $display("FAIL rnd_drop @%0d: got df=%b dc=%0d required %b %0d", cyc, drop_flag, drop_count, m_flag, exp_cnt(m_cnt));
            end
        end
        greset_req = 1'b0; sec_stop = '0; sec_start = '0; waitrequest = 1'b0; drop_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_start();
        test_priority();
        test_hold();
        test_drop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
